exe_stage: RTL and testbench

// - EXE pipeline stage; sits between ID and MEM. Latches id_to_exe_bus, computes ALU result or runs

---
 rtl/exe_stage_pkg.sv | 57 +++++
 rtl/exe_stage_if.sv | 47 ++++
 rtl/exe_stage_div.sv | 87 ++++++++
 rtl/exe_stage.sv | 83 ++++++++
 tb/tb_exe_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types for the EXE stage: pipeline bus layouts, ALU op indices, divider states.
// No logic; bus widths must stay in step with the ID and MEM stages.
// Helper abs32 gives the divider magnitude of an operand.
package exe_stage_pkg;

    localparam int ID_TO_EXE_WD  = 151;
    localparam int EXE_TO_MEM_WD = 71;

    // One-hot alu_op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [11:0] alu_op;
        logic        div_en;
        logic        div_signed;
        logic        div_rem;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        mem_we;
        logic        res_from_mem;
        logic        reg_w;
        logic [4:0]  reg_waddr;
        logic [31:0] pc;
    } id_to_exe_t;

    typedef struct packed {
        logic        reg_w;
        logic [4:0]  reg_waddr;
        logic        res_from_mem;
        logic [31:0] result;
        logic [31:0] pc;
    } exe_to_mem_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Magnitude of v when treated as signed (en=1), otherwise v unchanged.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// EXE stage neighbour signals: ID->EXE handshake, EXE->MEM handshake, hazard bus, data SRAM request.
// master = the EXE stage itself, slave = its surroundings (ID, MEM, SRAM).
// Purely a bundle of wires; no timing of its own.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic        exe_allowin;
    logic        id_to_exe_valid;
    id_to_exe_t  id_to_exe_bus;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    exe_to_mem_t exe_to_mem_bus;
    logic [5:0]  exe_to_id_bus;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        output exe_allowin,
        input  id_to_exe_valid,
        input  id_to_exe_bus,
        input  mem_allowin,
        output exe_to_mem_valid,
        output exe_to_mem_bus,
        output exe_to_id_bus,
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata
    );

    modport slave (
        input  exe_allowin,
        output id_to_exe_valid,
        output id_to_exe_bus,
        output mem_allowin,
        input  exe_to_mem_valid,
        input  exe_to_mem_bus,
        input  exe_to_id_bus,
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata
    );

endinterface

// File: rtl/exe_stage_div.sv
// Iterative 32-bit restoring divider with optional signed operands.
// Latency: start seen in IDLE, 32 BUSY cycles, done from the 33rd cycle after start.
// Holds DONE (results stable) until ack; ignores start outside IDLE.
module exe_div
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        div_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    input  logic        ack,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;     // shifts dividend out the top, quotient bits in the bottom
    logic [31:0] rem_q;
    logic [31:0] dvs_q;     // divisor magnitude
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        step_ge;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign step_ge = ~diff[32];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next state: 32 steps in BUSY, then wait in DONE for the instruction to leave
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start)              state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == 5'd31)     state_d = DIV_DONE;
            DIV_DONE: if (ack)                state_d = DIV_IDLE;
            default:                          state_d = DIV_IDLE;
        endcase
    end

    // Operand capture on start, then one shift-subtract step per BUSY cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        quo_q     <= abs32(a, div_signed);
                        dvs_q     <= abs32(b, div_signed);
                        rem_q     <= 32'd0;
                        cnt_q     <= 5'd0;
                        neg_quo_q <= div_signed & (a[31] ^ b[31]);
                        neg_rem_q <= div_signed & a[31];
                    end
                end
                DIV_BUSY: begin
                    rem_q <= step_ge ? diff[31:0] : shifted[31:0];
                    quo_q <= {quo_q[30:0], step_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign done = (state_q == DIV_DONE);
    assign quo  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: latches the ID payload, computes ALU result or runs the divider, issues data SRAM request.
// Latency: ALU ops ready on entry cycle; divides ready 33 cycles after entry.
// Stalls ID (exe_allowin=0) while a divide runs or MEM refuses; SRAM request repeats while held.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    exe_stage_if.master  pipe
);

    logic        exe_valid;
    id_to_exe_t  es_q;
    logic        exe_ready_go;

    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic [31:0] alu_result;
    logic [31:0] exe_result;
    logic [4:0]  shamt;

    assign exe_ready_go     = ~es_q.div_en | div_done;
    assign pipe.exe_allowin = ~exe_valid | (exe_ready_go & pipe.mem_allowin);

    // Stage valid bit advances whenever the stage can accept
    always_ff @(posedge clk) begin
        if (reset)                 exe_valid <= 1'b0;
        else if (pipe.exe_allowin) exe_valid <= pipe.id_to_exe_valid;
    end

    // Payload only captured on an actual transfer from ID
    always_ff @(posedge clk) begin
        if (reset)                                         es_q <= '0;
        else if (pipe.exe_allowin && pipe.id_to_exe_valid) es_q <= pipe.id_to_exe_bus;
    end

    exe_div u_div (
        .clk        (clk),
        .reset      (reset),
        .start      (exe_valid & es_q.div_en),
        .div_signed (es_q.div_signed),
        .a          (es_q.src1),
        .b          (es_q.src2),
        .done       (div_done),
        .ack        (pipe.mem_allowin),
        .quo        (div_quo),
        .rem        (div_rem)
    );

    assign shamt = es_q.src2[4:0];

    // One-hot AND-OR select of the single-cycle ALU operations
    always_comb begin
        alu_result = 32'd0;
        if (es_q.alu_op[ALU_ADD])  alu_result = alu_result | (es_q.src1 + es_q.src2);
        if (es_q.alu_op[ALU_SUB])  alu_result = alu_result | (es_q.src1 - es_q.src2);
        if (es_q.alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, $signed(es_q.src1) < $signed(es_q.src2)};
        if (es_q.alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, es_q.src1 < es_q.src2};
        if (es_q.alu_op[ALU_AND])  alu_result = alu_result | (es_q.src1 & es_q.src2);
        if (es_q.alu_op[ALU_NOR])  alu_result = alu_result | ~(es_q.src1 | es_q.src2);
        if (es_q.alu_op[ALU_OR])   alu_result = alu_result | (es_q.src1 | es_q.src2);
        if (es_q.alu_op[ALU_XOR])  alu_result = alu_result | (es_q.src1 ^ es_q.src2);
        if (es_q.alu_op[ALU_SLL])  alu_result = alu_result | (es_q.src1 << shamt);
        if (es_q.alu_op[ALU_SRL])  alu_result = alu_result | (es_q.src1 >> shamt);
        if (es_q.alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(es_q.src1) >>> shamt);
        if (es_q.alu_op[ALU_LUI])  alu_result = alu_result | es_q.src2;
    end

    assign exe_result = es_q.div_en ? (es_q.div_rem ? div_rem : div_quo) : alu_result;

    assign pipe.exe_to_mem_valid = exe_valid & exe_ready_go;
    assign pipe.exe_to_mem_bus   = {es_q.reg_w, es_q.reg_waddr, es_q.res_from_mem, exe_result, es_q.pc};
    assign pipe.exe_to_id_bus    = {exe_valid & es_q.reg_w, es_q.reg_waddr};

    // Memory address comes straight from the adder path; only word stores exist
    assign pipe.data_sram_en    = exe_valid & (es_q.mem_we | es_q.res_from_mem);
    assign pipe.data_sram_we    = {4{exe_valid & es_q.mem_we}};
    assign pipe.data_sram_addr  = alu_result;
    assign pipe.data_sram_wdata = es_q.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
    import exe_stage_pkg::*;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    // {div_en, div_signed, div_rem}
    localparam logic [2:0] DV_NONE = 3'b000;
    localparam logic [2:0] DV_W    = 3'b110;
    localparam logic [2:0] DV_MODW = 3'b111;
    localparam logic [2:0] DV_WU   = 3'b100;
    localparam logic [2:0] DV_MODU = 3'b101;

    typedef struct packed {
        logic [11:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] rkd;
        logic        we;
        logic        rfm;
        logic [31:0] exp_res;
        logic        exp_en;
        logic [3:0]  exp_we;
    } vec_t;

    localparam int NV = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_stage_if u_if ();
    exe_stage u_dut (.clk(clk), .reset(reset), .pipe(u_if));

    int   tests = 0;
    int   fails = 0;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic id_to_exe_t mk(input logic [11:0] op, input logic [2:0] dv,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic we, input logic rfm);
        id_to_exe_t t;
        t.alu_op       = op;
        t.div_en       = dv[2];
        t.div_signed   = dv[1];
        t.div_rem      = dv[0];
        t.src1         = s1;
        t.src2         = s2;
        t.rkd_value    = rkd;
        t.mem_we       = we;
        t.res_from_mem = rfm;
        t.reg_w        = ~we;
        t.reg_waddr    = 5'd5;
        t.pc           = 32'h1c00_0100;
        return t;
    endfunction

    task automatic start_div(input id_to_exe_t t);
        @(negedge clk);
        u_if.id_to_exe_valid = 1'b1;
        u_if.id_to_exe_bus   = t;
        @(negedge clk);
        u_if.id_to_exe_valid = 1'b0;
        #1;
    endtask

    // Called during entry cycle 0; waits for the result, optionally holds MEM, then either
    // feeds the next instruction in the leaving cycle or checks the divide left exactly once.
    task automatic div_wait(input string nm, input logic [31:0] exp, input int hold,
                            input bit chain, input id_to_exe_t nxt);
        int          cyc = 0;
        bit          bad = 1'b0;
        exe_to_mem_t snap;
        while (!u_if.exe_to_mem_valid && cyc < 100) begin
            if (u_if.exe_allowin || u_if.data_sram_en) bad = 1'b1;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_latency"}, 71'(cyc), 71'd33);
        chk({nm, "_stall"}, 71'(bad), 71'd0);
        chk({nm, "_result"}, 71'(u_if.exe_to_mem_bus.result), 71'(exp));
        if (hold > 0) begin
            snap = u_if.exe_to_mem_bus;
            bad  = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                if (!u_if.exe_to_mem_valid || u_if.exe_to_mem_bus !== snap || u_if.exe_allowin) bad = 1'b1;
            end
            chk({nm, "_hold"}, 71'(bad), 71'd0);
            u_if.mem_allowin = 1'b1;
        end
        if (chain) begin
            u_if.id_to_exe_valid = 1'b1;
            u_if.id_to_exe_bus   = nxt;
            @(negedge clk);
            u_if.id_to_exe_valid = 1'b0;
            #1;
        end else begin
            @(negedge clk);
            #1;
            chk({nm, "_left"}, 71'(u_if.exe_to_mem_valid), 71'd0);
        end
    endtask

    initial begin
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_we;
        logic        s_en;
        bit          bad;

        vt[0]  = '{OP_ADD,  32'd5,         32'd7,         32'h0,         1'b0, 1'b0, 32'd12,        1'b0, 4'h0};
        vt[1]  = '{OP_SUB,  32'd5,         32'd7,         32'h0,         1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'h0};
        vt[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0, 1'b0, 32'd1,         1'b0, 4'h0};
        vt[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0, 1'b0, 32'd0,         1'b0, 4'h0};
        vt[4]  = '{OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, 32'h0,         1'b0, 1'b0, 32'hF000_1200, 1'b0, 4'h0};
        vt[5]  = '{OP_NOR,  32'h0000_FFFF, 32'h00FF_0000, 32'h0,         1'b0, 1'b0, 32'hFF00_0000, 1'b0, 4'h0};
        vt[6]  = '{OP_OR,   32'h1200_0034, 32'h0034_1200, 32'h0,         1'b0, 1'b0, 32'h1234_1234, 1'b0, 4'h0};
        vt[7]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,         1'b0, 1'b0, 32'hF0F0_0F0F, 1'b0, 4'h0};
        vt[8]  = '{OP_SLL,  32'd1,         32'h0000_0023, 32'h0,         1'b0, 1'b0, 32'd8,         1'b0, 4'h0};
        vt[9]  = '{OP_SRL,  32'h8000_0000, 32'd31,        32'h0,         1'b0, 1'b0, 32'd1,         1'b0, 4'h0};
        vt[10] = '{OP_SRA,  32'h8000_0000, 32'd4,         32'h0,         1'b0, 1'b0, 32'hF800_0000, 1'b0, 4'h0};
        vt[11] = '{OP_LUI,  32'h0000_1234, 32'hABCD_0000, 32'h0,         1'b0, 1'b0, 32'hABCD_0000, 1'b0, 4'h0};
        vt[12] = '{OP_ADD,  32'h0000_1000, 32'd4,         32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_1004, 1'b1, 4'hF};
        vt[13] = '{OP_ADD,  32'h0000_2000, 32'h10,        32'h1111_2222, 1'b0, 1'b1, 32'h0000_2010, 1'b1, 4'h0};

        // Reset state
        reset                = 1'b1;
        u_if.id_to_exe_valid = 1'b0;
        u_if.id_to_exe_bus   = '0;
        u_if.mem_allowin     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid",   71'(u_if.exe_to_mem_valid), 71'd0);
        chk("rst_sram_en", 71'(u_if.data_sram_en),     71'd0);
        chk("rst_sram_we", 71'(u_if.data_sram_we),     71'd0);
        chk("rst_allowin", 71'(u_if.exe_allowin),      71'd1);
        reset = 1'b0;

        // Single-cycle ALU, load and store vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            u_if.id_to_exe_valid = 1'b1;
            u_if.id_to_exe_bus   = mk(vt[i].op, DV_NONE, vt[i].s1, vt[i].s2, vt[i].rkd, vt[i].we, vt[i].rfm);
            @(negedge clk);
            u_if.id_to_exe_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i),  71'(u_if.exe_to_mem_valid),          71'd1);
            chk($sformatf("v%0d_result", i), 71'(u_if.exe_to_mem_bus.result),     71'(vt[i].exp_res));
            chk($sformatf("v%0d_en", i),     71'(u_if.data_sram_en),              71'(vt[i].exp_en));
            chk($sformatf("v%0d_we", i),     71'(u_if.data_sram_we),              71'(vt[i].exp_we));
            chk($sformatf("v%0d_addr", i),   71'(u_if.data_sram_addr),            71'(vt[i].exp_res));
            chk($sformatf("v%0d_wdata", i),  71'(u_if.data_sram_wdata),           71'(vt[i].rkd));
            chk($sformatf("v%0d_hazard", i), 71'(u_if.exe_to_id_bus),             71'({~vt[i].we, 5'd5}));
        end
        @(negedge clk);
        #1;
        chk("alu_drained", 71'(u_if.exe_to_mem_valid), 71'd0);

        // Store held by MEM backpressure: request repeats unchanged
        @(negedge clk);
        u_if.id_to_exe_valid = 1'b1;
        u_if.id_to_exe_bus   = mk(OP_ADD, DV_NONE, 32'h0000_3000, 32'h8, 32'hCAFE_F00D, 1'b1, 1'b0);
        u_if.mem_allowin     = 1'b0;
        @(negedge clk);
        u_if.id_to_exe_valid = 1'b0;
        #1;
        s_en = u_if.data_sram_en; s_we = u_if.data_sram_we;
        s_addr = u_if.data_sram_addr; s_wdata = u_if.data_sram_wdata;
        chk("st_hold_addr", 71'(s_addr), 71'h3008);
        bad = 1'b0;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            #1;
            if (u_if.data_sram_en !== s_en || u_if.data_sram_we !== s_we ||
                u_if.data_sram_addr !== s_addr || u_if.data_sram_wdata !== s_wdata ||
                u_if.exe_allowin !== 1'b0 || u_if.exe_to_mem_valid !== 1'b1) bad = 1'b1;
        end
        chk("st_hold_stable", 71'(bad), 71'd0);
        u_if.mem_allowin = 1'b1;
        @(negedge clk);
        #1;
        chk("st_hold_left", 71'(u_if.exe_to_mem_valid), 71'd0);

        // div.w -7/2 then mod.w -7/2 entering in the leaving cycle
        start_div(mk(12'h0, DV_W, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b0));
        div_wait("divw_m7_2", 32'hFFFF_FFFD, 0, 1'b1, mk(12'h0, DV_MODW, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b0));
        div_wait("modw_m7_2", 32'hFFFF_FFFF, 0, 1'b0, '0);

        // Unsigned divide by zero
        start_div(mk(12'h0, DV_WU, 32'd10, 32'd0, 32'h0, 1'b0, 1'b0));
        div_wait("divwu_10_0", 32'hFFFF_FFFF, 0, 1'b1, mk(12'h0, DV_MODU, 32'd10, 32'd0, 32'h0, 1'b0, 1'b0));
        div_wait("modwu_10_0", 32'd10, 0, 1'b0, '0);

        // Signed overflow case, held 3 cycles by MEM after completion
        u_if.mem_allowin = 1'b0;
        start_div(mk(12'h0, DV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        div_wait("divw_ovf", 32'h8000_0000, 3, 1'b1, mk(12'h0, DV_MODW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        div_wait("modw_ovf", 32'd0, 0, 1'b0, '0);

        // Reset during cycle 10 of a divide
        start_div(mk(12'h0, DV_W, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid",   71'(u_if.exe_to_mem_valid), 71'd0);
        chk("mid_rst_en",      71'(u_if.data_sram_en),     71'd0);
        chk("mid_rst_allowin", 71'(u_if.exe_allowin),      71'd1);
        start_div(mk(12'h0, DV_WU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0));
        div_wait("divwu_100_7", 32'd14, 0, 1'b1, mk(12'h0, DV_MODU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0));
        div_wait("modwu_100_7", 32'd2, 0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
